// File: rtl/note_tone_gen.sv
// note_tone_gen: MIDI note to 50%-duty square-wave tone with articulation gap on note change
// Ports:
//   clk        100 MHz system clock
//   reset      synchronous active-high reset
//   note       0 = rest, 1..127 = MIDI note number (69 = A4 = 440 Hz)
//   mute       forces audio_out low without disturbing internal state
//   audio_out  square-wave tone
//   playing    high while the tone is being generated
//   note_start one-cycle pulse on the cycle the tone starts
module note_tone_gen #(
  parameter int GAP_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] note,
  input  logic       mute,
  output logic       audio_out,
  output logic       playing,
  output logic       note_start
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, GAP, PLAY} state_t;
  state_t      r_state;
  logic [6:0]  r_cur_note;
  logic [GW-1:0] r_gap_cnt;
  logic [22:0] r_phase_cnt;
  logic        r_tone;
  logic        r_note_start;
  logic [3:0]  w_semi;
  logic [3:0]  w_oct;
  logic [22:0] w_base;
  logic [22:0] w_half;
  logic        w_change;
  assign w_change = note != r_cur_note;
  assign w_semi   = 4'(r_cur_note % 7'd12);
  assign w_oct    = 4'(r_cur_note / 7'd12);
  // Octave-0 half-periods in clk cycles; each octave up halves the count.
  always_comb begin
    case (w_semi)
      4'd0:    w_base = 23'd6115610;
      4'd1:    w_base = 23'd5772367;
      4'd2:    w_base = 23'd5448389;
      4'd3:    w_base = 23'd5142595;
      4'd4:    w_base = 23'd4853963;
      4'd5:    w_base = 23'd4581531;
      4'd6:    w_base = 23'd4324390;
      4'd7:    w_base = 23'd4081680;
      4'd8:    w_base = 23'd3852593;
      4'd9:    w_base = 23'd3636364;
      4'd10:   w_base = 23'd3432270;
      4'd11:   w_base = 23'd3239632;
      default: w_base = 23'd0;
    endcase
  end
  assign w_half = w_base >> w_oct;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cur_note   <= '0;
      r_gap_cnt    <= '0;
      r_phase_cnt  <= '0;
      r_tone       <= 1'b0;
      r_note_start <= 1'b0;
    end else begin
      r_note_start <= 1'b0;
      if (w_change) begin
        // A change always restarts articulation, even in the middle of a gap.
        r_cur_note  <= note;
        r_gap_cnt   <= '0;
        r_phase_cnt <= '0;
        r_tone      <= 1'b0;
        if (GAP_CYCLES == 0) begin
          r_state      <= note != 7'd0 ? PLAY : IDLE;
          r_note_start <= note != 7'd0;
        end else begin
          r_state <= GAP;
        end
      end else if (r_state == GAP) begin
        if (r_gap_cnt == GAP_LAST) begin
          r_state      <= r_cur_note != 7'd0 ? PLAY : IDLE;
          r_note_start <= r_cur_note != 7'd0;
          r_phase_cnt  <= '0;
          r_tone       <= 1'b0;
        end else begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
        end
      end else if (r_state == PLAY) begin
        if (r_phase_cnt == w_half - 23'd1) begin
          r_tone      <= ~r_tone;
          r_phase_cnt <= '0;
        end else begin
          r_phase_cnt <= r_phase_cnt + 23'd1;
        end
      end
    end
  end
  assign playing    = r_state == PLAY;
  assign note_start = r_note_start;
  assign audio_out  = r_tone & ~mute & playing;
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: scoreboard bench for note_tone_gen (gap of 4 cycles and a zero-gap build side by side)
module tb_note_tone_gen;
  localparam int G = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mute = 1'b0;
  logic [6:0] note = 7'd0;
  logic       audio [2];
  logic       play [2];
  logic       ns [2];
  note_tone_gen #(.GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .note(note), .mute(mute),
    .audio_out(audio[0]), .playing(play[0]), .note_start(ns[0])
  );
  note_tone_gen #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .note(note), .mute(mute),
    .audio_out(audio[1]), .playing(play[1]), .note_start(ns[1])
  );
  always #5 clk = ~clk;
  typedef struct {
    int   t;
    int   inst;
    int   kind;
    logic val;
  } ev_t;
  ev_t   sb[$];
  int    cyc = 0;
  int    vectors = 0;
  int    errors = 0;
  bit    armed = 1'b0;
  int    mc [2] = '{0, 0};
  int    chg [2] = '{0, 0};
  logic  pp [2] = '{1'b0, 1'b0};
  logic  pa [2] = '{1'b0, 1'b0};
  logic  lp [2] = '{1'b0, 1'b0};
  logic  la [2] = '{1'b0, 1'b0};
  logic  rq;
  string kname [3] = '{"note_start", "playing", "audio_out"};
  // Half-period straight from the tuning formula: round(1e8 / (2*f0*2^(s/12))) >> octave.
  function automatic int half_of(input int n);
    real b;
    b = 100.0e6 / (2.0 * 8.1757989 * (2.0 ** (real'(n % 12) / 12.0)));
    return $rtoi(b + 0.5) >> (n / 12);
  endfunction
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask
  // Reference: after a change at edge c the tone starts at c+gap and toggles every half-period.
  task automatic step(input int t, input logic [6:0] n, input logic m, input logic r);
    int   g;
    logic pl;
    logic st;
    logic au;
    for (int k = 0; k < 2; k++) begin
      g = k == 0 ? G : 0;
      if (r) mc[k] = 0;
      else if (int'(n) != mc[k]) begin
        mc[k]  = int'(n);
        chg[k] = t;
      end
      pl = mc[k] != 0 && t >= chg[k] + g;
      st = pl && t == chg[k] + g;
      au = 1'b0;
      if (pl && !m) au = ((t - chg[k] - g) / half_of(mc[k])) % 2 == 1;
      if (st) sb.push_back('{t, k, 0, 1'b1});
      if (pl != pp[k]) sb.push_back('{t, k, 1, pl});
      if (au != pa[k]) sb.push_back('{t, k, 2, au});
      pp[k] = pl;
      pa[k] = au;
    end
  endtask
  task automatic seg(input logic [6:0] n, input logic m, input logic r, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      note  = n;
      mute  = m;
      reset = r;
      armed = 1'b1;
      step(cyc + 1, n, m, r);
    end
  endtask
  task automatic expect_ev(input int k, input int kind, input logic v);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event: got dut%0d %s=%0d at cycle %0d, expected no event", k, kname[kind], v, cyc);
    end else begin
      e = sb.pop_front();
      if (e.t != cyc || e.inst != k || e.kind != kind || e.val !== v) begin
        errors++;
        $display("FAIL event: got dut%0d %s=%0d at cycle %0d, expected dut%0d %s=%0d at cycle %0d",
                 k, kname[kind], v, cyc, e.inst, kname[e.kind], e.val, e.t);
      end
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rq = reset;
      #1;
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          if (ns[k]) expect_ev(k, 0, 1'b1);
          if (play[k] != lp[k]) expect_ev(k, 1, play[k]);
          if (audio[k] != la[k]) expect_ev(k, 2, audio[k]);
          lp[k] = play[k];
          la[k] = audio[k];
          if (rq) check($sformatf("reset_state dut%0d", k), int'({audio[k], play[k], ns[k]}), 0);
        end
      end
    end
  end
  initial begin
    logic [6:0] n;
    logic [6:0] last;
    int         r;
    seg(7'd0, 1'b0, 1'b1, 3);
    seg(7'd0, 1'b0, 1'b0, 5);
    seg(7'd127, 1'b0, 1'b0, 5000);
    seg(7'd127, 1'b1, 1'b0, 1000);
    seg(7'd127, 1'b0, 1'b0, 3000);
    seg(7'd0, 1'b0, 1'b0, 10);
    seg(7'd120, 1'b0, 1'b0, 2);
    seg(7'd122, 1'b0, 1'b0, 6000);
    seg(7'd115, 1'b0, 1'b1, 3);
    seg(7'd115, 1'b0, 1'b0, 9000);
    seg(7'd110, 1'b0, 1'b0, 4);
    seg(7'd111, 1'b0, 1'b0, 4);
    seg(7'd112, 1'b0, 1'b0, 300);
    last = 7'd112;
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 9);
      n = r < 2 ? 7'd0 : r < 4 ? last : 7'($urandom_range(108, 127));
      if ($urandom_range(0, 15) == 0) seg(n, 1'b0, 1'b1, $urandom_range(1, 3));
      seg(n, 1'($urandom_range(0, 3) == 0), 1'b0, $urandom_range(1, 3000));
      last = n;
    end
    seg(7'd0, 1'b0, 1'b0, 20);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
